display_mux_2dig: RTL and testbench

DISPLAY_MUX_2DIG -- requirements
Module: display_mux_2dig

---
 rtl/display_pkg.sv | 32 +++
 rtl/seg7_encode.sv | 27 ++
 rtl/display_mux_2dig.sv | 128 ++++++++++++
 tb/tb_display_mux_2dig.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed display.
// Leading-zero blanking of the tens digit is enabled by LEADING_ZERO_BLANK_EN.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_e;

  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_GUARD       = 500;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/seg7_encode.sv
// BCD to seven-segment decoder, active-high, seg[0]=a .. seg[6]=g.
// Non-decimal codes show a dash.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux_2dig.sv
// Two-digit time-multiplexed 7-seg driver with guard blanking and tear-free
// frame update. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module display_mux_2dig
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    stg0_q, stg0_d;
  logic [3:0]    stg1_q, stg1_d;
  logic [3:0]    sh0_q, sh0_d;
  logic [3:0]    sh1_q, sh1_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          last;
  logic          frame_start;
  logic [3:0]    enc_in;
  logic [6:0]    enc_out;

  seg7_encode u_enc (
    .bcd_i (enc_in),
    .seg_o (enc_out)
  );

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    unique case (state_q)
      SHOW0: begin
        last = (cnt_q == CW'(REFRESH_DIV - 1));
        if (last) state_d = BLANK0;
      end
      BLANK0: begin
        last = (cnt_q == CW'(GUARD - 1));
        if (last) state_d = SHOW1;
      end
      SHOW1: begin
        last = (cnt_q == CW'(REFRESH_DIV - 1));
        if (last) state_d = BLANK1;
      end
      BLANK1: begin
        last = (cnt_q == CW'(GUARD - 1));
        if (last) state_d = SHOW0;
      end
    endcase
    cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  // A load in the frame-start cycle goes straight to the shadows.
  always_comb begin
    frame_start = (state_q == BLANK1) && last;
    stg0_d = load ? digit0 : stg0_q;
    stg1_d = load ? digit1 : stg1_q;
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    if (frame_start) begin
      sh0_d = stg0_d;
      sh1_d = stg1_d;
    end
  end

  assign enc_in = (state_d == SHOW1) ? sh1_d : sh0_d;

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    unique case (1'b1)
      (state_d == SHOW0): begin
        seg_d = enc_out;
        an_d  = AN_UNITS;
      end
      (state_d == SHOW1): begin
`ifdef LEADING_ZERO_BLANK_EN
        if (sh1_d != 4'd0) begin
          seg_d = enc_out;
          an_d  = AN_TENS;
        end
`else
        seg_d = enc_out;
        an_d  = AN_TENS;
`endif
      end
      default: begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      stg0_q  <= '0;
      stg1_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg0_q  <= stg0_d;
      stg1_q  <= stg1_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_mux_2dig.sv
// Scoreboard bench for display_mux_2dig with REFRESH_DIV=4, GUARD=1.
// Expected an/seg per cycle are queued by stimulus and checked by a monitor.
module tb_display_mux_2dig;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [6:0] seg;
  logic [1:0] an;

  typedef struct {
    int         cyc;
    logic [1:0] an;
    logic [6:0] seg;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] SD = 7'b1000000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [1:0] T0_AN  = 2'b11;
  localparam logic [6:0] T0_SEG = 7'b0000000;
`else
  localparam logic [1:0] T0_AN  = 2'b01;
  localparam logic [6:0] T0_SEG = 7'b0111111;
`endif

  display_mux_2dig #(
    .REFRESH_DIV (4),
    .GUARD       (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .digit0 (digit0),
    .digit1 (digit1),
    .seg    (seg),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] a,
                      input logic [6:0] s, input string t);
    exp_t e;
    e.cyc = c;
    e.an  = a;
    e.seg = s;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int s, input logic [6:0] u,
                            input logic [1:0] ta, input logic [6:0] ts,
                            input string t);
    for (int i = 0; i < 4; i++) push(s + i, 2'b10, u, {t, "_show0"});
    push(s + 4, 2'b11, 7'b0, {t, "_blank0"});
    for (int i = 0; i < 4; i++) push(s + 5 + i, ta, ts, {t, "_show1"});
    push(s + 9, 2'b11, 7'b0, {t, "_blank1"});
  endtask

  task automatic wait_neg(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_load(input logic [3:0] d0, input logic [3:0] d1);
    load   = 1'b1;
    digit0 = d0;
    digit1 = d1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || an !== e.an || seg !== e.seg) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d an=%b seg=%b required an=%b seg=%b",
                 e.tag, cyc, e.cyc, an, seg, e.an, e.seg);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int f;
    reset  = 1'b0;
    load   = 1'b0;
    digit0 = 4'd0;
    digit1 = 4'd0;

    repeat (3) @(posedge clk);
    #2;
    c = cyc;
    push(c, 2'b11, 7'b0, "in_reset");
    push(c + 1, 2'b10, S0, "first_show0");
    push(c + 2, 2'b10, S0, "first_show0");
    reset = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    push(c + 3, 2'b11, 7'b0, "reset_mid_show0");
    reset = 1'b0;

    @(posedge clk);
    #2;
    push(c + 4, 2'b11, 7'b0, "reset_held");
    reset = 1'b1;
    f = c + 5;
    push_frame(f, S0, T0_AN, T0_SEG, "zero_frame");

    wait_neg(f + 2);
    do_load(4'd7, 4'd5);
    push_frame(f + 10, S7, 2'b01, S5, "frame75");

    wait_neg(f + 16);
    do_load(4'd3, 4'd5);
    push_frame(f + 20, S3, 2'b01, S5, "frame35");

    wait_neg(f + 22);
    do_load(4'd12, 4'd5);
    push_frame(f + 30, SD, 2'b01, S5, "dash");

    wait_neg(f + 39);
    do_load(4'd1, 4'd2);
    push_frame(f + 40, S1, 2'b01, S2, "bypass");

    wait_neg(f + 42);
    do_load(4'd4, 4'd0);
    push_frame(f + 50, S4, T0_AN, T0_SEG, "tens_zero");

    wait_neg(f + 61);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
